// File: rtl/appr_mult_sequencer.sv
// Batch initiator for appr_multiplier: fetches N_JOBS operand pairs, starts each multiply, writes products back.
// Job cost is 4 cycles plus WAIT cycles; no backpressure, waits up to TIMEOUT cycles per mul_done then aborts.
module appr_mult_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int N_JOBS  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_a,
  input  logic [DATA_W-1:0]   mem_b,
  output logic                mul_start,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                res_we,
  output logic [ADDR_W-1:0]   res_addr,
  output logic [2*DATA_W-1:0] res_data,
  output logic                busy,
  output logic                batch_done,
  output logic                timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_JOBS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              last_job;
  logic              wait_expired;

  assign last_job     = (idx == IDX_LAST);
  // Expires on the TIMEOUT-th WAIT cycle; a done in that same cycle still wins.
  assign wait_expired = (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mul_start  = 1'b0;
    res_we     = 1'b0;
    batch_done = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: begin
        mul_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          state_nxt = S_WRITE;
        end else if (wait_expired) begin
          state_nxt = S_FINISH;
        end
      end
      S_WRITE: begin
        res_we    = 1'b1;
        state_nxt = last_job ? S_FINISH : S_FETCH;
      end
      S_FINISH: begin
        batch_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // mem_addr/res_addr are loaded on entry to FETCH/WRITE so they hold through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      res_addr    <= '0;
      res_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            idx         <= '0;
            mem_addr    <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_LOAD: begin
          mul_a <= mem_a;
          mul_b <= mem_b;
        end
        S_START: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mul_done) begin
            res_data <= mul_result;
            res_addr <= idx;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
          end
        end
        S_WRITE: begin
          if (!last_job) begin
            idx      <= idx + 1'b1;
            mem_addr <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_appr_mult_sequencer.sv
// Randomized scoreboard bench for appr_mult_sequencer with a mock memory and mock multiplier.
module tb_appr_mult_sequencer;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NJ = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            go;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_a;
  logic [DW-1:0]   mem_b;
  logic            mul_start;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic            mul_done;
  logic [2*DW-1:0] mul_result;
  logic            res_we;
  logic [AW-1:0]   res_addr;
  logic [2*DW-1:0] res_data;
  logic            busy;
  logic            batch_done;
  logic            timeout_err;

  appr_mult_sequencer #(.DATA_W(DW), .ADDR_W(AW), .N_JOBS(NJ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go),
    .mem_addr(mem_addr), .mem_a(mem_a), .mem_b(mem_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .batch_done(batch_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
  } wr_t;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] a_arr [2**AW];
  logic [DW-1:0] b_arr [2**AW];
  int            dly [NJ];
  int            mode = 0;        // 0 normal, 1 never done, 2 spurious done in START
  wr_t           exp_q [$];
  bit            exp_to_q [$];
  int            wr_cnt = 0;
  int            bd_cnt = 0;
  int            busy_cnt = 0;
  int            start_cnt = 0;
  logic [AW-1:0] rd_addr_d = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mock synchronous memory (one-cycle read latency) and mock multiplier.
  initial begin
    int               cnt;
    bit               pend;
    logic [2*DW-1:0]  prod;
    cnt = 0; pend = 0; prod = '0;
    mul_done = 1'b0; mul_result = '0; mem_a = '0; mem_b = '0;
    forever begin
      @(negedge clk);
      mem_a     = a_arr[rd_addr_d];
      mem_b     = b_arr[rd_addr_d];
      rd_addr_d = mem_addr;
      mul_done  = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mul_done   = 1'b1;
            mul_result = prod;
            pend       = 0;
          end
        end
        if (mul_start) begin
          prod = (2*DW)'(mul_a) * (2*DW)'(mul_b);
          cnt  = dly[start_cnt % NJ];
          start_cnt++;
          pend = (mode != 1);
          if (mode == 2) begin
            mul_done   = 1'b1;
            mul_result = ~prod;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes a result or ends a batch.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) busy_cnt++;
        if (res_we) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got addr %0d data %0d, required no write", res_addr, res_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(res_addr), 64'(e.addr));
            check("wr_data", 64'(res_data), 64'(e.data));
          end
        end
        if (batch_done) begin
          bd_cnt++;
          if (exp_to_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_batch_done: got pulse, required none");
          end else begin
            check("timeout_err_at_done", 64'(timeout_err), 64'(exp_to_q.pop_front()));
          end
        end
      end
    end
  end

  function automatic int exp_busy(input int m);
    int s = 1;
    if (m == 1) return 3 + TO + 1;
    for (int j = 0; j < NJ; j++) s += 4 + dly[j];
    return s;
  endfunction

  task automatic issue(input int m);
    wr_t e;
    mode = m; start_cnt = 0; wr_cnt = 0; bd_cnt = 0; busy_cnt = 0;
    if (m == 1) begin
      exp_to_q.push_back(1'b1);
    end else begin
      for (int j = 0; j < NJ; j++) begin
        e.addr = AW'(j);
        e.data = (2*DW)'(longint'(a_arr[j]) * longint'(b_arr[j]));
        exp_q.push_back(e);
      end
      exp_to_q.push_back(1'b0);
    end
    go = 1'b1;
    @(negedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (start_cnt < n && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    if (start_cnt < n) begin
      tests++; fails++;
      $display("FAIL wait_start: got %0d starts, required %0d", start_cnt, n);
    end
  endtask

  task automatic finish_batch(input string name, input int m);
    int k = 0;
    while (bd_cnt == 0 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (20) begin
      @(negedge clk); #1;
    end
    check({name, "_batch_done_cnt"}, 64'(bd_cnt), 64'd1);
    check({name, "_write_cnt"}, 64'(wr_cnt), (m == 1) ? 64'd0 : 64'(NJ));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy(m)));
    check({name, "_timeout_err"}, 64'(timeout_err), (m == 1) ? 64'd1 : 64'd0);
    check({name, "_leftover_exp"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({name, "_mul_start"}, 64'(mul_start), 64'd0);
    check({name, "_mul_a"}, 64'(mul_a), 64'd0);
    check({name, "_mul_b"}, 64'(mul_b), 64'd0);
    check({name, "_res_we"}, 64'(res_we), 64'd0);
    check({name, "_res_addr"}, 64'(res_addr), 64'd0);
    check({name, "_res_data"}, 64'(res_data), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_batch_done"}, 64'(batch_done), 64'd0);
    check({name, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  task automatic rand_ops(input int dmax);
    for (int j = 0; j < 2**AW; j++) begin
      a_arr[j] = DW'($urandom);
      b_arr[j] = DW'($urandom);
    end
    for (int j = 0; j < NJ; j++) dly[j] = $urandom_range(dmax, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    for (int j = 0; j < 2**AW; j++) begin a_arr[j] = '0; b_arr[j] = '0; end
    for (int j = 0; j < NJ; j++) dly[j] = 3;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk); #1;

    // Directed batch.
    a_arr[0] = 16'd3;     b_arr[0] = 16'd5;
    a_arr[1] = 16'd7;     b_arr[1] = 16'd2;
    a_arr[2] = 16'd0;     b_arr[2] = 16'd9;
    a_arr[3] = 16'd65535; b_arr[3] = 16'd2;
    issue(0);
    finish_batch("directed", 0);
    check("directed_starts", 64'(start_cnt), 64'(NJ));

    // go during WAIT of job 1 must be ignored.
    issue(0);
    wait_starts(2);
    @(negedge clk); #1;
    go = 1'b1;
    @(negedge clk); #1;
    go = 1'b0;
    finish_batch("go_in_wait", 0);

    // Random operands and done latencies, including done on the last allowed WAIT cycle.
    for (int b = 0; b < 5; b++) begin
      rand_ops(TO);
      if (b == 0) for (int j = 0; j < NJ; j++) dly[j] = TO;
      issue(0);
      finish_batch("random", 0);
    end

    // Multiplier never answers: abort on first job.
    rand_ops(3);
    issue(1);
    finish_batch("timeout", 1);

    // A new go clears the sticky flag.
    issue(0);
    check("go_clears_timeout_err", 64'(timeout_err), 64'd0);
    check("restart_mem_addr", 64'(mem_addr), 64'd0);
    finish_batch("after_timeout", 0);

    // mul_done during START only must be ignored; real done follows later.
    rand_ops(5);
    issue(2);
    finish_batch("done_in_start", 2);

    // Async reset during WAIT of job 2, then a clean restart.
    rand_ops(3);
    for (int j = 0; j < NJ; j++) dly[j] = 3;
    issue(0);
    wait_starts(3);
    @(negedge clk); #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    check("mid_reset_writes_before", 64'(wr_cnt), 64'd2);
    exp_q.delete();
    exp_to_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    rand_ops(4);
    a_arr[0] = 16'd1234;
    b_arr[0] = 16'd3;
    issue(0);
    check("post_reset_mem_addr", 64'(mem_addr), 64'd0);
    finish_batch("post_reset", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
